load_store_unit: RTL

//  Sequential memory-access unit between the pipeline MEM stage and the data memory.
//  - Accepts one load/store request per transaction over a valid/ready handshake.
//  - Generates byte enables and lane-replicated store data, then waits on a memory ack.
//  - Aligns returned load data and sign/zero-extends it by funct3 (LB/LH/LW/LBU/LHU, plus LD/LWU when XLEN=64).
//  - Returns a single-cycle response with an error flag.

---
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request in, byte-lane memory access with ack timeout, aligned/extended response out.
// Optional feature macro MISALIGN_SPLIT_EN: word-crossing accesses are split into two memory accesses.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state;

  logic [OFFW-1:0]   off;
  logic [7:0]        size_mask;
  logic              illegal;
  logic              bad;
  logic              more;
  logic [NB-1:0]     be1;
  logic [XLEN-1:0]   wd1;
  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   shifted;

  logic              r_we;
  logic              r_err;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   ld_data;

  assign off       = req_addr[OFFW-1:0];
  assign word_addr = req_addr & ~ADDR_W'(NB - 1);

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign illegal = (req_funct3 == 3'b111) ||
                   ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));

`ifdef MISALIGN_SPLIT_EN
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] wd_full;
  logic [2*XLEN-1:0] rd_pair;
  logic              split;
  logic              r_split;
  logic [NB-1:0]     r_be2;
  logic [XLEN-1:0]   r_wd2;
  logic [XLEN-1:0]   rdata_lo;
  logic [ADDR_W-1:0] r_addr2;

  // Double-width lane masks/data: the upper half is what spills into the next word.
  assign be_full = (2*NB)'(size_mask) << off;
  assign wd_full = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
  assign split   = |be_full[2*NB-1:NB];
  assign bad     = illegal;
  assign be1     = be_full[NB-1:0];
  assign wd1     = wd_full[XLEN-1:0];
  assign more    = (state == ACC1) && r_split;
  assign rd_pair = (state == ACC2) ? {mem_rdata, rdata_lo} : {{XLEN{1'b0}}, mem_rdata};
  assign shifted = XLEN'(rd_pair >> {r_off, 3'b000});
`else
  logic misaligned;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign bad     = illegal | misaligned;
  assign be1     = NB'(size_mask) << off;
  assign wd1     = req_wdata << {off, 3'b000};
  assign more    = 1'b0;
  assign shifted = mem_rdata >> {r_off, 3'b000};
`endif

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
    int unsigned bits;
    int unsigned sh;
    logic [XLEN-1:0]        t;
    logic signed [XLEN-1:0] s;
    bits = 32'd8 << f3[1:0];
    if (bits >= XLEN) return d;
    sh = XLEN - bits;
    t  = d << sh;
    s  = t;
    s  = s >>> sh;
    return f3[2] ? (t >> sh) : s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_funct3  <= '0;
      r_off     <= '0;
      cnt       <= '0;
      ld_data   <= '0;
`ifdef MISALIGN_SPLIT_EN
      r_split   <= 1'b0;
      r_be2     <= '0;
      r_wd2     <= '0;
      rdata_lo  <= '0;
      r_addr2   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_off     <= off;
            cnt       <= '0;
            ld_data   <= '0;
            if (bad) begin
              r_err <= 1'b1;
              state <= RESP;
            end else begin
              r_err     <= 1'b0;
              state     <= ACC1;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= word_addr;
              mem_be    <= be1;
              mem_wdata <= wd1;
`ifdef MISALIGN_SPLIT_EN
              r_split   <= split;
              r_be2     <= be_full[2*NB-1:NB];
              r_wd2     <= wd_full[2*XLEN-1:XLEN];
              r_addr2   <= word_addr + ADDR_W'(NB);
`endif
            end
          end
        end
        ACC1, ACC2: begin
          if (mem_ack && more) begin
            state <= ACC2;
            cnt   <= '0;
`ifdef MISALIGN_SPLIT_EN
            mem_addr  <= r_addr2;
            mem_be    <= r_be2;
            mem_wdata <= r_wd2;
            rdata_lo  <= mem_rdata;
`endif
          end else if (mem_ack || (cnt == CW'(TIMEOUT - 1))) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            r_err     <= !mem_ack;
            ld_data   <= mem_ack ? extend(shifted, r_funct3) : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= r_err;
          rsp_rdata <= (r_we || r_err) ? '0 : ld_data;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
